// File: rtl/snn_ctrl_pkg.sv
// Shared definitions for the AER scheduler sequencing controller:
// event type encodings, controller state encoding and word-count helper.
package snn_ctrl_pkg;

    localparam logic [1:0] VIRT_SPIKE = 2'b00;
    localparam logic [1:0] VIRT_TSTEP = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DECODE,
        S_PROC,
        S_TSTEP,
        S_DONE
    } state_t;

    function automatic int calc_words(input int outs, input int par);
        return outs / par;
    endfunction

endpackage

// File: rtl/sched_sweep_cnt.sv
// Post-neuron word sweep counter with enable, terminal flag and the
// synapse address (pre_addr * WORDS + word).
// Ports: clk, rst_n, clr (word <= 0), en (advance one word),
//        pre_addr (latched event address), word, last, syn_addr.
module sched_sweep_cnt
    import snn_ctrl_pkg::*;
#(
    parameter int WORDS  = 64,
    parameter int PRE_W  = 10,
    parameter int WORD_W = 8,
    parameter int SYN_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [PRE_W-1:0]  pre_addr,
    output logic [WORD_W-1:0] word,
    output logic              last,
    output logic [SYN_W-1:0]  syn_addr
);

    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);

    assign last = (word == WORD_LAST);

    // Wrapping back to zero on the final word leaves the counter ready for
    // the next sweep even if no explicit clear arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (clr) begin
            word <= '0;
        end else if (en) begin
            word <= last ? '0 : word + 1'b1;
        end
    end

    assign syn_addr = SYN_W'(pre_addr) * SYN_W'(WORDS) + SYN_W'(word);

endmodule

// File: rtl/sched_event_ctrl.sv
// Drains the AER scheduler FIFO and sequences per-event synapse sweeps and
// time-step markers across an inference window of TIME_STEP steps.
// Ports: CLK, RSTN, START, SCHED_EMPTY, SCHED_DATA_OUT, STALL in;
//        CTRL_SCHED_POP_N, CTRL_PRE_NEUR_ADDR, CTRL_POST_NEUR_WORD_ADDR,
//        CTRL_SYN_ADDR, CTRL_SYN_RE, CTRL_TSTEP, CTRL_TSTEP_END, BUSY, DONE,
//        ERR_ADDR out.
module sched_event_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int TIME_STEP                 = 8,
    parameter int INPUT_NEURON              = 784,
    parameter int OUTPUT_NEURON             = 256,
    parameter int POST_NEUR_PARALLEL        = 4,
    parameter int PRE_NEUR_ADDR_WIDTH       = 10,
    parameter int POST_NEUR_WORD_ADDR_WIDTH = 8,
    parameter int SYN_ARRAY_ADDR_WIDTH      = 16,
    parameter int AER_IN_WIDTH              = 12,
    localparam int TW = $clog2(TIME_STEP) + 1
) (
    input  logic                                 CLK,
    input  logic                                 RSTN,
    input  logic                                 START,
    input  logic                                 SCHED_EMPTY,
    input  logic [AER_IN_WIDTH-1:0]              SCHED_DATA_OUT,
    input  logic                                 STALL,
    output logic                                 CTRL_SCHED_POP_N,
    output logic [PRE_NEUR_ADDR_WIDTH-1:0]       CTRL_PRE_NEUR_ADDR,
    output logic [POST_NEUR_WORD_ADDR_WIDTH-1:0] CTRL_POST_NEUR_WORD_ADDR,
    output logic [SYN_ARRAY_ADDR_WIDTH-1:0]      CTRL_SYN_ADDR,
    output logic                                 CTRL_SYN_RE,
    output logic [TW-1:0]                        CTRL_TSTEP,
    output logic                                 CTRL_TSTEP_END,
    output logic                                 BUSY,
    output logic                                 DONE,
    output logic                                 ERR_ADDR
);

    localparam int WORDS = calc_words(OUTPUT_NEURON, POST_NEUR_PARALLEL);
    localparam logic [TW-1:0] TS_LAST = TW'(TIME_STEP - 1);

    state_t state, state_n;

    logic [1:0]                     ev_virts;
    logic [PRE_NEUR_ADDR_WIDTH-1:0] ev_addr;
    logic ev_ld, cnt_clr, cnt_en, last;
    logic win_clr, err_set, ts_inc;
    logic pop_n, re, ts_end;
    logic in_range;

    assign in_range = (32'(ev_addr) < INPUT_NEURON);

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        pop_n   = 1'b1;
        ev_ld   = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        re      = 1'b0;
        ts_end  = 1'b0;
        ts_inc  = 1'b0;
        win_clr = 1'b0;
        err_set = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (START) begin
                    win_clr = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!SCHED_EMPTY) begin
                    pop_n   = 1'b0;
                    ev_ld   = 1'b1;
                    state_n = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ev_virts == VIRT_SPIKE && in_range) begin
                    cnt_clr = 1'b1;
                    state_n = S_PROC;
                end else if (ev_virts == VIRT_TSTEP) begin
                    state_n = S_TSTEP;
                end else begin
                    err_set = 1'b1;
                    state_n = S_WAIT;
                end
            end
            S_PROC: begin
                if (!STALL) begin
                    re     = 1'b1;
                    cnt_en = 1'b1;
                    if (last) state_n = S_WAIT;
                end
            end
            S_TSTEP: begin
                ts_end  = 1'b1;
                ts_inc  = 1'b1;
                state_n = (CTRL_TSTEP == TS_LAST) ? S_DONE : S_WAIT;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            ev_virts <= '0;
            ev_addr  <= '0;
        end else if (ev_ld) begin
            ev_virts <= SCHED_DATA_OUT[AER_IN_WIDTH-1 -: 2];
            ev_addr  <= SCHED_DATA_OUT[PRE_NEUR_ADDR_WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            CTRL_TSTEP <= '0;
            ERR_ADDR   <= 1'b0;
        end else begin
            if (win_clr) CTRL_TSTEP <= '0;
            else if (ts_inc) CTRL_TSTEP <= CTRL_TSTEP + 1'b1;
            if (win_clr) ERR_ADDR <= 1'b0;
            else if (err_set) ERR_ADDR <= 1'b1;
        end
    end

    sched_sweep_cnt #(
        .WORDS  (WORDS),
        .PRE_W  (PRE_NEUR_ADDR_WIDTH),
        .WORD_W (POST_NEUR_WORD_ADDR_WIDTH),
        .SYN_W  (SYN_ARRAY_ADDR_WIDTH)
    ) u_cnt (
        .clk      (CLK),
        .rst_n    (RSTN),
        .clr      (cnt_clr),
        .en       (cnt_en),
        .pre_addr (ev_addr),
        .word     (CTRL_POST_NEUR_WORD_ADDR),
        .last     (last),
        .syn_addr (CTRL_SYN_ADDR)
    );

    assign CTRL_SCHED_POP_N   = pop_n;
    assign CTRL_PRE_NEUR_ADDR = ev_addr;
    assign CTRL_SYN_RE        = re;
    assign CTRL_TSTEP_END     = ts_end;
    assign BUSY = (state != S_IDLE) && (state != S_DONE);
    assign DONE = (state == S_DONE);

endmodule

// File: tb/tb_sched_event_ctrl.sv
// Self-checking bench for sched_event_ctrl: event-level reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_sched_event_ctrl;

    localparam int WORDS = 64;
    localparam int TS    = 8;
    localparam int NIN   = 784;

    localparam int P_IDLE = 0, P_WAIT = 1, P_DEC = 2;
    localparam int P_SWEEP = 3, P_MARK = 4, P_DONE = 5;

    logic        CLK = 1'b0;
    logic        RSTN, START, SCHED_EMPTY, STALL;
    logic [11:0] SCHED_DATA_OUT;
    logic        pop_n, syn_re, tstep_end, busy, done, err;
    logic [9:0]  pre_addr;
    logic [7:0]  word;
    logic [15:0] syn_addr;
    logic [3:0]  tstep;

    always #5 CLK = ~CLK;

    sched_event_ctrl dut (
        .CLK                      (CLK),
        .RSTN                     (RSTN),
        .START                    (START),
        .SCHED_EMPTY              (SCHED_EMPTY),
        .SCHED_DATA_OUT           (SCHED_DATA_OUT),
        .STALL                    (STALL),
        .CTRL_SCHED_POP_N         (pop_n),
        .CTRL_PRE_NEUR_ADDR       (pre_addr),
        .CTRL_POST_NEUR_WORD_ADDR (word),
        .CTRL_SYN_ADDR            (syn_addr),
        .CTRL_SYN_RE              (syn_re),
        .CTRL_TSTEP               (tstep),
        .CTRL_TSTEP_END           (tstep_end),
        .BUSY                     (busy),
        .DONE                     (done),
        .ERR_ADDR                 (err)
    );

    // Event-level reference model: which activity the controller is in,
    // the event it holds and how far through its sweep it is.
    int          m_phase, m_tstep, m_word;
    logic        m_err;
    logic [11:0] m_ev;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_phase <= P_IDLE;
            m_tstep <= 0;
            m_word  <= 0;
            m_err   <= 1'b0;
            m_ev    <= '0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: if (START) begin
                    m_phase <= P_WAIT;
                    m_tstep <= 0;
                    m_err   <= 1'b0;
                end
                P_WAIT: if (!SCHED_EMPTY) begin
                    m_ev    <= SCHED_DATA_OUT;
                    m_phase <= P_DEC;
                end
                P_DEC: begin
                    if (m_ev[11:10] == 2'b00 && int'(m_ev[9:0]) < NIN) begin
                        m_word  <= 0;
                        m_phase <= P_SWEEP;
                    end else if (m_ev[11:10] == 2'b01) begin
                        m_phase <= P_MARK;
                    end else begin
                        m_err   <= 1'b1;
                        m_phase <= P_WAIT;
                    end
                end
                P_SWEEP: if (!STALL) begin
                    m_word  <= (m_word + 1) % WORDS;
                    if (m_word == WORDS - 1) m_phase <= P_WAIT;
                end
                P_MARK: begin
                    m_tstep <= m_tstep + 1;
                    m_phase <= (m_tstep + 1 == TS) ? P_DONE : P_WAIT;
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    int checks = 0, errors = 0;
    int cycle = 0;
    logic [11:0] fifo[$];

    int re_cnt, first_syn, last_syn, first_re_cyc, last_re_cyc;
    int tend_cnt, pop_cnt, pop_cyc, push_cyc;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic fifo_sync();
        SCHED_EMPTY    = (fifo.size() == 0);
        SCHED_DATA_OUT = (fifo.size() == 0) ? 12'h000 : fifo[0];
    endtask

    task automatic push(input logic [1:0] v, input int a);
        fifo.push_back({v, 10'(a)});
        fifo_sync();
    endtask

    task automatic clear_stats();
        re_cnt = 0; first_syn = -1; last_syn = -1;
        first_re_cyc = -1; last_re_cyc = -1;
        tend_cnt = 0; pop_cnt = 0; pop_cyc = -1;
    endtask

    task automatic compare_all();
        bit exp_pop, exp_re;
        exp_pop = (m_phase == P_WAIT) && !SCHED_EMPTY;
        exp_re  = (m_phase == P_SWEEP) && !STALL;
        chk("pop_n", int'(pop_n), int'(!exp_pop));
        chk("pre_addr", int'(pre_addr), int'(m_ev[9:0]));
        chk("word", int'(word), m_word);
        chk("syn_addr", int'(syn_addr), int'(m_ev[9:0]) * WORDS + m_word);
        chk("syn_re", int'(syn_re), int'(exp_re));
        chk("tstep", int'(tstep), m_tstep);
        chk("tstep_end", int'(tstep_end), int'(m_phase == P_MARK));
        chk("busy", int'(busy),
            int'(m_phase != P_IDLE && m_phase != P_DONE));
        chk("done", int'(done), int'(m_phase == P_DONE));
        chk("err", int'(err), int'(m_err));
    endtask

    task automatic tick();
        bit pop_now;
        @(negedge CLK);
        cycle++;
        compare_all();
        pop_now = !pop_n;
        if (pop_now) begin
            pop_cnt++;
            pop_cyc = cycle;
        end
        if (syn_re) begin
            re_cnt++;
            if (first_syn < 0) begin
                first_syn = int'(syn_addr);
                first_re_cyc = cycle;
            end
            last_syn = int'(syn_addr);
            last_re_cyc = cycle;
        end
        if (tstep_end) tend_cnt++;
        @(posedge CLK);
        if (pop_now && RSTN && fifo.size() > 0) void'(fifo.pop_front());
        #1;
        fifo_sync();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic wait_pop(input int bound);
        for (int i = 0; i < bound && pop_cnt == 0; i++) tick();
        chk("wait_pop", pop_cnt, 1);
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        ticks(2);
        RSTN = 1'b1;
        fifo.delete();
        fifo_sync();
    endtask

    initial begin
        RSTN = 1'b1; START = 1'b0; STALL = 1'b0;
        fifo_sync();
        #1 RSTN = 1'b0;
        #1;
        chk("rst_pop_n", int'(pop_n), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_syn", int'(syn_addr), 0);
        @(posedge CLK); #1;
        do_reset();

        // Spike at 5 then a marker
        clear_stats();
        push(2'b00, 5);
        push(2'b01, 0);
        pulse_start();
        ticks(80);
        chk("t1_re_cnt", re_cnt, 64);
        chk("t1_first", first_syn, 320);
        chk("t1_last", last_syn, 383);
        chk("t1_tend", tend_cnt, 1);
        chk("t1_tstep", int'(tstep), 1);
        chk("t1_pops", pop_cnt, 2);

        // Eight markers close the window; later entries are left alone
        do_reset();
        for (int i = 0; i < 10; i++) push(2'b01, 0);
        clear_stats();
        pulse_start();
        ticks(40);
        chk("t2_tend", tend_cnt, 8);
        chk("t2_done", int'(done), 1);
        chk("t2_busy", int'(busy), 0);
        chk("t2_pops", pop_cnt, 8);
        chk("t2_left", fifo.size(), 2);
        chk("t2_tstep", int'(tstep), 8);

        // Restart from DONE; top address with a 3-cycle stall at word 10
        fifo.delete();
        fifo_sync();
        pulse_start();
        chk("t3_tstep_clr", int'(tstep), 0);
        chk("t3_busy", int'(busy), 1);
        clear_stats();
        push(2'b00, 783);
        wait_pop(5);
        ticks(11);
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_stall_re", int'(syn_re), 0);
            chk("t3_stall_word", int'(word), 10);
            tick();
        end
        STALL = 1'b0;
        ticks(60);
        chk("t3_re_cnt", re_cnt, 64);
        chk("t3_last", last_syn, 50175);
        chk("t3_span", last_re_cyc - first_re_cyc + 1, 67);

        // Out-of-range and reserved events are dropped
        chk("t4_err_before", int'(err), 0);
        clear_stats();
        push(2'b00, 800);
        push(2'b10, 3);
        ticks(10);
        chk("t4_err", int'(err), 1);
        chk("t4_re", re_cnt, 0);
        chk("t4_pops", pop_cnt, 2);

        // Empty FIFO wait, then a late push
        do_reset();
        pulse_start();
        clear_stats();
        ticks(20);
        chk("t5_pops", pop_cnt, 0);
        chk("t5_busy", int'(busy), 1);
        push(2'b00, 1);
        push_cyc = cycle + 1;
        wait_pop(3);
        chk("t5_pop_cyc", pop_cyc - push_cyc, 0);
        ticks(5);
        chk("t5_lat", first_re_cyc - pop_cyc, 2);
        chk("t5_first", first_syn, 64);
        ticks(70);

        // Async reset in the middle of a sweep
        clear_stats();
        push(2'b00, 2);
        wait_pop(3);
        ticks(31);
        #1;
        chk("t6_word30", int'(word), 30);
        #1 RSTN = 1'b0;
        #1;
        chk("t6_pop_n", int'(pop_n), 1);
        chk("t6_busy", int'(busy), 0);
        chk("t6_re", int'(syn_re), 0);
        chk("t6_word", int'(word), 0);
        chk("t6_syn", int'(syn_addr), 0);
        chk("t6_pre", int'(pre_addr), 0);
        tick();
        RSTN = 1'b1;
        clear_stats();
        push(2'b00, 4);
        ticks(10);
        chk("t6_no_pop", pop_cnt, 0);
        chk("t6_idle_done", int'(done), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
